// File: rtl/fifo_pkt_writer_if.sv
// fifo_pkt_writer_if: bundles the upstream payload stream, the downstream FIFO
// write port and the status outputs of fifo_pkt_writer.
//   upstream : i_s_valid, o_s_ready, i_s_data, i_s_last
//   fifo     : i_full, o_wren, o_dataW
//   status   : o_busy, o_trunc, o_pkt_cnt
// Modport slave is the framer's view; master is the view of the logic around it.
interface fifo_pkt_writer_if #(
  parameter int unsigned g_width = 8
);
  logic               i_s_valid;
  logic               o_s_ready;
  logic [g_width-1:0] i_s_data;
  logic               i_s_last;
  logic               i_full;
  logic               o_wren;
  logic [g_width-1:0] o_dataW;
  logic               o_busy;
  logic               o_trunc;
  logic [15:0]        o_pkt_cnt;

  modport slave (
    input  i_s_valid, i_s_data, i_s_last, i_full,
    output o_s_ready, o_wren, o_dataW, o_busy, o_trunc, o_pkt_cnt
  );

  modport master (
    output i_s_valid, i_s_data, i_s_last, i_full,
    input  o_s_ready, o_wren, o_dataW, o_busy, o_trunc, o_pkt_cnt
  );
endinterface

// File: rtl/fifo_pkt_writer.sv
// fifo_pkt_writer: wraps each upstream packet into a frame written to a FIFO:
//   HDR (g_sof), payload words..., LEN (payload word count), CHK (XOR of payload).
// Packets longer than g_max_len are cut; the cut frame is closed with LEN/CHK,
// o_trunc pulses once, and the remaining words start a new frame.
// Ports:
//   i_clkW   - write-domain clock, rising edge
//   i_arstnW - asynchronous active-low reset
//   bus      - fifo_pkt_writer_if.slave (upstream stream, FIFO write port, status)
module fifo_pkt_writer #(
  parameter int unsigned g_width   = 8,
  parameter int unsigned g_max_len = 64,
  parameter logic [31:0] g_sof     = 32'hA5
) (
  input  logic                  i_clkW,
  input  logic                  i_arstnW,
  fifo_pkt_writer_if.slave      bus
);

  localparam logic [g_width-1:0] SOF    = g_sof[g_width-1:0];
  localparam logic [g_width-1:0] MAX_M1 = g_width'(g_max_len - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_LEN,
    S_CHK
  } state_t;

  state_t             state_q, state_d;
  logic [g_width-1:0] cnt_q, cnt_d;
  logic [g_width-1:0] chk_q, chk_d;
  logic [15:0]        pkt_cnt_q, pkt_cnt_d;
  logic               trunc_q, trunc_d;

  logic               wren;
  logic               s_ready;
  logic [g_width-1:0] data_w;
  logic               at_max;

  assign at_max = (cnt_q == MAX_M1);

  always_ff @(posedge i_clkW or negedge i_arstnW) begin
    if (!i_arstnW) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      chk_q     <= '0;
      pkt_cnt_q <= '0;
      trunc_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      chk_q     <= chk_d;
      pkt_cnt_q <= pkt_cnt_d;
      trunc_q   <= trunc_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    chk_d     = chk_q;
    pkt_cnt_d = pkt_cnt_q;
    trunc_d   = 1'b0;
    wren      = 1'b0;
    s_ready   = 1'b0;
    data_w    = '0;

    case (state_q)
      S_IDLE: begin
        // HDR is only emitted once a payload word is actually waiting.
        if (bus.i_s_valid && !bus.i_full) begin
          wren    = 1'b1;
          data_w  = SOF;
          cnt_d   = '0;
          chk_d   = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        s_ready = !bus.i_full;
        if (bus.i_s_valid && !bus.i_full) begin
          wren   = 1'b1;
          data_w = bus.i_s_data;
          cnt_d  = cnt_q + 1'b1;
          chk_d  = chk_q ^ bus.i_s_data;
          if (bus.i_s_last || at_max) begin
            state_d = S_LEN;
          end
          // Pulse only when the length limit, not the packet end, closes the frame.
          trunc_d = at_max && !bus.i_s_last;
        end
      end
      S_LEN: begin
        if (!bus.i_full) begin
          wren    = 1'b1;
          data_w  = cnt_q;
          state_d = S_CHK;
        end
      end
      S_CHK: begin
        if (!bus.i_full) begin
          wren      = 1'b1;
          data_w    = chk_q;
          pkt_cnt_d = pkt_cnt_q + 16'd1;
          state_d   = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.o_wren    = wren;
  assign bus.o_dataW   = data_w;
  assign bus.o_s_ready = s_ready;
  assign bus.o_busy    = (state_q != S_IDLE);
  assign bus.o_trunc   = trunc_q;
  assign bus.o_pkt_cnt = pkt_cnt_q;

endmodule

// File: tb/tb_fifo_pkt_writer.sv
module tb_fifo_pkt_writer;
  localparam int unsigned W    = 8;
  localparam int unsigned MAXL = 4;

  logic clk   = 1'b0;
  logic arstn = 1'b0;
  always #5 clk = ~clk;

  fifo_pkt_writer_if #(.g_width(W)) bus ();

  fifo_pkt_writer #(
    .g_width  (W),
    .g_max_len(MAXL),
    .g_sof    (32'hA5)
  ) dut (
    .i_clkW  (clk),
    .i_arstnW(arstn),
    .bus     (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [7:0] d;
    logic       last;
  } tx_t;

  typedef struct {
    logic       valid;
    logic       full;
    logic [7:0] data;
    logic       exp_wren;
    logic       exp_ready;
    logic [7:0] exp_dataW;
  } vec_t;

  logic [7:0] exp_q[$];
  tx_t        tx_q[$];
  bit         mon_en    = 1'b0;
  int         trunc_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected frames: split into chunks of MAXL, each wrapped as HDR, words, LEN, CHK.
  function automatic void model_pkt(input logic [7:0] w[$]);
    int unsigned cnt = 0;
    logic [7:0]  x   = '0;
    for (int i = 0; i < w.size(); i++) begin
      if (cnt == 0) begin
        exp_q.push_back(8'hA5);
        x = '0;
      end
      exp_q.push_back(w[i]);
      x ^= w[i];
      cnt++;
      if (cnt == MAXL || i == w.size() - 1) begin
        exp_q.push_back(8'(cnt));
        exp_q.push_back(x);
        cnt = 0;
      end
      tx_q.push_back('{d: w[i], last: (i == w.size() - 1)});
    end
  endfunction

  // Scoreboard: every FIFO write pops one expected word.
  always @(negedge clk) begin
    if (mon_en && arstn) begin
      if (bus.o_trunc) trunc_cnt++;
      if (bus.i_full) check("no_wr_or_ready_when_full", {30'd0, bus.o_wren, bus.o_s_ready}, 32'd0);
      if (bus.o_wren) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_write: got 0x%0h expected no write", bus.o_dataW);
        end else begin
          check("fifo_word", bus.o_dataW, exp_q.pop_front());
        end
      end else begin
        check("dataW_zero_no_wren", bus.o_dataW, 32'd0);
      end
    end
  end

  task automatic drive_all(input int budget);
    int cyc = 0;
    while (tx_q.size() > 0) begin
      @(posedge clk); #1;
      bus.i_s_valid = 1'b1;
      bus.i_s_data  = tx_q[0].d;
      bus.i_s_last  = tx_q[0].last;
      @(negedge clk);
      if (bus.o_s_ready) void'(tx_q.pop_front());
      cyc++;
      if (cyc > budget) begin
        n_tests++;
        n_fail++;
        $display("FAIL drive_timeout: got %0d words left expected 0", tx_q.size());
        tx_q.delete();
      end
    end
    @(posedge clk); #1;
    bus.i_s_valid = 1'b0;
    bus.i_s_last  = 1'b0;
    bus.i_s_data  = '0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    bit ok = 1'b0;
    repeat (budget) begin
      @(negedge clk);
      if (!bus.o_busy) begin
        ok = 1'b1;
        break;
      end
    end
    check(name, {31'd0, ok}, 32'd1);
  endtask

  task automatic wait_write(input logic [7:0] v);
    bit ok = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if (bus.o_wren && bus.o_dataW == v) begin
        ok = 1'b1;
        break;
      end
    end
    check("stall_sync", {31'd0, ok}, 32'd1);
  endtask

  task automatic stall_seq();
    wait_write(8'h11);
    @(posedge clk); #1 bus.i_full = 1'b1;
    repeat (5) @(posedge clk);
    #1 bus.i_full = 1'b0;
    wait_write(8'h33);
    @(posedge clk); #1 bus.i_full = 1'b1;
    repeat (5) @(posedge clk);
    #1 bus.i_full = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    vec_t       vt[4];
    logic [7:0] p[$];

    vt[0] = '{valid: 1'b0, full: 1'b0, data: 8'h3C, exp_wren: 1'b0, exp_ready: 1'b0, exp_dataW: 8'h00};
    vt[1] = '{valid: 1'b0, full: 1'b1, data: 8'h3C, exp_wren: 1'b0, exp_ready: 1'b0, exp_dataW: 8'h00};
    vt[2] = '{valid: 1'b1, full: 1'b1, data: 8'h3C, exp_wren: 1'b0, exp_ready: 1'b0, exp_dataW: 8'h00};
    vt[3] = '{valid: 1'b1, full: 1'b0, data: 8'h3C, exp_wren: 1'b1, exp_ready: 1'b0, exp_dataW: 8'hA5};

    bus.i_s_valid = 1'b0;
    bus.i_s_data  = '0;
    bus.i_s_last  = 1'b0;
    bus.i_full    = 1'b0;

    // Reset state
    #12;
    check("rst_wren",  {31'd0, bus.o_wren},    32'd0);
    check("rst_ready", {31'd0, bus.o_s_ready}, 32'd0);
    check("rst_dataW", bus.o_dataW,            32'd0);
    check("rst_busy",  {31'd0, bus.o_busy},    32'd0);
    check("rst_trunc", {31'd0, bus.o_trunc},   32'd0);
    check("rst_pktcnt", {16'd0, bus.o_pkt_cnt}, 32'd0);
    @(negedge clk);
    arstn = 1'b1;

    // IDLE combinational vectors; valid is withdrawn before the edge so no frame starts
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      bus.i_s_valid = vt[i].valid;
      bus.i_full    = vt[i].full;
      bus.i_s_data  = vt[i].data;
      @(negedge clk);
      check($sformatf("vec%0d_wren", i),  {31'd0, bus.o_wren},    {31'd0, vt[i].exp_wren});
      check($sformatf("vec%0d_ready", i), {31'd0, bus.o_s_ready}, {31'd0, vt[i].exp_ready});
      check($sformatf("vec%0d_dataW", i), bus.o_dataW,            {24'd0, vt[i].exp_dataW});
      check($sformatf("vec%0d_busy", i),  {31'd0, bus.o_busy},    32'd0);
      #1;
      bus.i_s_valid = 1'b0;
      bus.i_full    = 1'b0;
    end
    mon_en = 1'b1;

    // Single packet
    p = {8'h11, 8'h22, 8'h33};
    model_pkt(p);
    drive_all(50);
    wait_idle("single_idle", 20);
    check("single_pktcnt", {16'd0, bus.o_pkt_cnt}, 32'd1);

    // One-word packet
    p = {8'h5A};
    model_pkt(p);
    drive_all(50);
    wait_idle("oneword_busy_fall", 20);
    check("oneword_pktcnt", {16'd0, bus.o_pkt_cnt}, 32'd2);

    // Backpressure in DATA and LEN
    p = {8'h11, 8'h22, 8'h33};
    model_pkt(p);
    fork
      drive_all(80);
      stall_seq();
    join
    wait_idle("stall_idle", 40);
    check("stall_pktcnt", {16'd0, bus.o_pkt_cnt}, 32'd3);
    check("pre_trunc_cnt", trunc_cnt, 32'd0);

    // Truncation at MAXL
    p = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    model_pkt(p);
    drive_all(80);
    wait_idle("trunc_idle", 20);
    check("trunc_pktcnt", {16'd0, bus.o_pkt_cnt}, 32'd5);
    check("trunc_pulses", trunc_cnt, 32'd1);

    // Reset mid-frame after HDR + 2 payload words
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h10);
    exp_q.push_back(8'h20);
    tx_q.push_back('{d: 8'h10, last: 1'b0});
    tx_q.push_back('{d: 8'h20, last: 1'b0});
    drive_all(50);
    check("midrst_partial_written", exp_q.size(), 32'd0);
    check("midrst_busy_before", {31'd0, bus.o_busy}, 32'd1);
    #1 arstn = 1'b0;
    #1;
    check("midrst_wren",   {31'd0, bus.o_wren},    32'd0);
    check("midrst_ready",  {31'd0, bus.o_s_ready}, 32'd0);
    check("midrst_dataW",  bus.o_dataW,            32'd0);
    check("midrst_busy",   {31'd0, bus.o_busy},    32'd0);
    check("midrst_pktcnt", {16'd0, bus.o_pkt_cnt}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    arstn = 1'b1;
    p = {8'h77};
    model_pkt(p);
    drive_all(50);
    wait_idle("midrst_idle", 20);
    check("midrst_after_pktcnt", {16'd0, bus.o_pkt_cnt}, 32'd1);

    // Back-to-back two-word packets with valid held high
    p = {8'hC1, 8'hC2};
    model_pkt(p);
    p = {8'hD1, 8'hD2};
    model_pkt(p);
    p = {8'hE1, 8'hE2};
    model_pkt(p);
    drive_all(100);
    wait_idle("b2b_idle", 20);
    check("b2b_pktcnt", {16'd0, bus.o_pkt_cnt}, 32'd4);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 32'd0);
    check("final_trunc_pulses", trunc_cnt, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
